// File: rtl/ss_pkg.sv
// Shared types and size helpers for the SS matrix initiator.
package ss_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, RECV} state_t;

  localparam int unsigned N_SMALL  = 4;
  localparam int unsigned N_LARGE  = 8;
  localparam int unsigned MAX_ELEM = 64;

  function automatic logic [3:0] n_of(input logic size);
    return size ? 4'(N_LARGE) : 4'(N_SMALL);
  endfunction

  function automatic logic [6:0] elems_of(input logic size);
    return size ? 7'(N_LARGE * N_LARGE) : 7'(N_SMALL * N_SMALL);
  endfunction

endpackage

// File: rtl/ss_tx_buf.sv
// Matrix staging buffer: one write port, one registered read port.
module ss_tx_buf #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 64,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [AW-1:0]     i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Read register clears when not reading so it can drive the SS element bus directly.
  always_ff @(posedge clk) begin
    if (!rst_n)       r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
    else              r_rd_data <= '0;
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/ss_matrix_tx.sv
// SS matrix initiator: buffers a host matrix, streams it to SS, forwards the result burst.
module ss_matrix_tx
  import ss_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned OUT_W   = 40,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_size,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              busy,
  output logic              in_valid,
  output logic [DATA_W-1:0] matrix,
  output logic              matrix_size,
  input  logic              out_valid,
  input  logic [OUT_W-1:0]  out_value,
  output logic              res_valid,
  output logic [OUT_W-1:0]  res_data,
  output logic              res_last,
  output logic              timeout_err
);

  localparam int unsigned TW = $clog2(TIMEOUT);

  state_t          r_state, w_next;
  logic            r_size;
  logic [5:0]      r_wr_cnt, r_rd_cnt;
  logic [2:0]      r_res_cnt;
  logic [TW-1:0]   r_timer;
  logic            r_in_valid, r_matrix_size, r_res_valid, r_res_last, r_timeout;
  logic [OUT_W-1:0] r_res_data;

  logic            w_accept, w_load_done, w_send_more, w_res_fire, w_res_done, w_timeout;
  logic [6:0]      w_elems_m1;
  logic [3:0]      w_n_m1;
  logic [5:0]      w_last_elem, w_rd_addr;
  logic [2:0]      w_last_res;
  logic            w_rd_en;

  assign wr_ready    = (r_state == IDLE) || (r_state == LOAD);
  assign busy        = (r_state != IDLE);
  assign w_accept    = wr_valid && wr_ready;
  assign w_elems_m1  = elems_of(r_size) - 7'd1;
  assign w_n_m1      = n_of(r_size) - 4'd1;
  assign w_last_elem = w_elems_m1[5:0];
  assign w_last_res  = w_n_m1[2:0];

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_load_done = 1'b0;
    w_send_more = 1'b0;
    w_res_fire  = 1'b0;
    w_res_done  = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: if (w_accept) w_next = LOAD;
      LOAD: if (w_accept && (r_wr_cnt == w_last_elem)) begin
        w_load_done = 1'b1;
        w_next      = SEND;
      end
      SEND: if (r_rd_cnt == w_last_elem) w_next = WAIT;
            else                         w_send_more = 1'b1;
      WAIT, RECV: begin
        if (out_valid) begin
          w_res_fire = 1'b1;
          w_res_done = (r_res_cnt == w_last_res);
          w_next     = w_res_done ? IDLE : RECV;
        end else if ((r_state == WAIT) && (r_timer == TW'(TIMEOUT - 1))) begin
          w_timeout = 1'b1;
          w_next    = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Element 0 is prefetched on the accepting edge of the last word, so each SEND
  // edge fetches one ahead of the element currently on the bus.
  assign w_rd_en   = w_load_done || w_send_more;
  assign w_rd_addr = w_load_done ? '0 : r_rd_cnt + 6'd1;

  ss_tx_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (MAX_ELEM)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_accept),
    .i_wr_addr (r_wr_cnt),
    .i_wr_data (wr_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (matrix)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_size        <= 1'b0;
      r_wr_cnt      <= '0;
      r_rd_cnt      <= '0;
      r_res_cnt     <= '0;
      r_timer       <= '0;
      r_in_valid    <= 1'b0;
      r_matrix_size <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_data    <= '0;
      r_res_last    <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      if ((r_state == IDLE) && w_accept) r_size <= cfg_size;
      if (w_load_done)   r_wr_cnt <= '0;
      else if (w_accept) r_wr_cnt <= r_wr_cnt + 6'd1;
      r_rd_cnt      <= w_send_more ? r_rd_cnt + 6'd1 : '0;
      r_timer       <= ((r_state == WAIT) && (w_next == WAIT)) ? r_timer + TW'(1) : '0;
      if (w_res_done)      r_res_cnt <= '0;
      else if (w_res_fire) r_res_cnt <= r_res_cnt + 3'd1;
      r_in_valid    <= w_rd_en;
      r_matrix_size <= w_load_done && r_size;
      r_res_valid   <= w_res_fire;
      r_res_data    <= w_res_fire ? out_value : '0;
      r_res_last    <= w_res_done;
      r_timeout     <= w_timeout;
    end
  end

  assign in_valid    = r_in_valid;
  assign matrix_size = r_matrix_size;
  assign res_valid   = r_res_valid;
  assign res_data    = r_res_data;
  assign res_last    = r_res_last;
  assign timeout_err = r_timeout;

endmodule

// File: tb/tb_ss_matrix_tx.sv
// Directed self-checking bench for ss_matrix_tx with a scripted SS responder.
module tb_ss_matrix_tx;

  localparam int unsigned DW = 16;
  localparam int unsigned OW = 40;
  localparam int unsigned TO = 1024;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_size;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          busy;
  logic          in_valid;
  logic [DW-1:0] matrix;
  logic          matrix_size;
  logic          out_valid;
  logic [OW-1:0] out_value;
  logic          res_valid;
  logic [OW-1:0] res_data;
  logic          res_last;
  logic          timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  ss_matrix_tx #(
    .DATA_W  (DW),
    .OUT_W   (OW),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_size    (cfg_size),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .busy        (busy),
    .in_valid    (in_valid),
    .matrix      (matrix),
    .matrix_size (matrix_size),
    .out_valid   (out_valid),
    .out_value   (out_value),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_last    (res_last),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Host writes n words base..base+n-1; spur drives out_valid during the load.
  task automatic write_words(input logic sz, input int n, input int base, input logic spur);
    for (int i = 0; i < n; i++) begin
      check("wr_ready_load", 64'(wr_ready), 64'd1);
      cfg_size  = sz;
      wr_valid  = 1'b1;
      wr_data   = DW'(base + i);
      out_valid = spur;
      out_value = OW'(40'hDEAD);
      tick();
      if (spur) check("spurious_res_valid", 64'(res_valid), 64'd0);
    end
    wr_valid  = 1'b0;
    wr_data   = '0;
    out_valid = 1'b0;
    out_value = '0;
  endtask

  // Checks ncyc SEND cycles; when ncyc covers the matrix, also checks the drop to idle bus.
  task automatic check_send(input logic sz, input int n, input int ncyc, input int base);
    for (int k = 0; k < ncyc; k++) begin
      check("in_valid", 64'(in_valid), 64'd1);
      check("matrix", 64'(matrix), 64'(DW'(base + k)));
      check("matrix_size", 64'(matrix_size), (k == 0) ? 64'(sz) : 64'd0);
      if (k == 0) check("wr_ready_send", 64'(wr_ready), 64'd0);
      tick();
    end
    if (ncyc == n) begin
      check("in_valid_end", 64'(in_valid), 64'd0);
      check("matrix_end", 64'(matrix), 64'd0);
      check("busy_wait", 64'(busy), 64'd1);
    end
  endtask

  // SS returns n results base..; gap inserts one idle out_valid cycle between them.
  task automatic ss_results(input int n, input logic gap, input logic [OW-1:0] base);
    for (int j = 0; j < n; j++) begin
      out_valid = 1'b1;
      out_value = base + OW'(j);
      tick();
      out_valid = 1'b0;
      out_value = '0;
      check("res_valid", 64'(res_valid), 64'd1);
      check("res_data", 64'(res_data), 64'(base + OW'(j)));
      check("res_last", 64'(res_last), (j == n - 1) ? 64'd1 : 64'd0);
      if (gap && j != n - 1) begin
        tick();
        check("res_valid_gap", 64'(res_valid), 64'd0);
      end
    end
    tick();
    check("res_valid_after", 64'(res_valid), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
    check("wr_ready_idle", 64'(wr_ready), 64'd1);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; cfg_size = 1'b0; wr_valid = 1'b0; wr_data = '0;
    out_valid = 1'b0; out_value = '0;
    tick(); tick();
    check("rst_wr_ready", 64'(wr_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_valid", 64'(in_valid), 64'd0);
    check("rst_matrix", 64'(matrix), 64'd0);
    check("rst_matrix_size", 64'(matrix_size), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_data", 64'(res_data), 64'd0);
    check("rst_res_last", 64'(res_last), 64'd0);
    check("rst_timeout", 64'(timeout_err), 64'd0);
    rst_n = 1'b1;

    // 4x4: elements 1..16
    write_words(1'b0, 16, 1, 1'b0);
    check_send(1'b0, 16, 16, 1);
    ss_results(4, 1'b0, 40'h10);

    // 8x8: elements 0..63, results 0xA000000001..
    write_words(1'b1, 64, 0, 1'b0);
    check_send(1'b1, 64, 64, 0);
    ss_results(8, 1'b0, 40'hA0_0000_0001);

    // Timeout: no results ever
    write_words(1'b0, 16, 100, 1'b0);
    check_send(1'b0, 16, 16, 100);
    cnt = 0;
    while (!timeout_err && cnt < int'(TO) + 10) begin
      tick();
      cnt++;
    end
    check("timeout_cycles", 64'(cnt), 64'(TO));
    check("timeout_busy", 64'(busy), 64'd0);
    check("timeout_wr_ready", 64'(wr_ready), 64'd1);
    tick();
    check("timeout_pulse", 64'(timeout_err), 64'd0);

    // Gapped results
    write_words(1'b0, 16, 200, 1'b0);
    check_send(1'b0, 16, 16, 200);
    ss_results(4, 1'b1, 40'h12_3456_7890);

    // Reset after 10 of 16 elements sent
    write_words(1'b0, 16, 300, 1'b0);
    check_send(1'b0, 16, 10, 300);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_in_valid", 64'(in_valid), 64'd0);
    check("midrst_matrix", 64'(matrix), 64'd0);
    check("midrst_wr_ready", 64'(wr_ready), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    write_words(1'b0, 16, 400, 1'b0);
    check_send(1'b0, 16, 16, 400);
    ss_results(4, 1'b0, 40'h55);

    // Spurious out_valid while loading
    write_words(1'b0, 16, 500, 1'b1);
    check_send(1'b0, 16, 16, 500);
    ss_results(4, 1'b0, 40'h77);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
